// File: rtl/ram16k_bist.sv
// ram16k_bist: sequencing front-end for the 16K x 16 data RAM.
// In IDLE the CPU port passes straight through to the RAM with no added latency.
// On start it takes over the RAM and runs one of two sequences:
//   mode=0 (clear) writes the latched fill value to every word;
//   mode=1 (self-test) writes an address-unique pattern, then reads it back.
// The self-test reports a sticky fail flag and the first failing address.
// Ports:
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_start, i_mode      sequence request and type (latched on acceptance)
//   i_fill               clear-mode data (latched on acceptance)
//   i_cpu_in/add/load    CPU write data, address, write enable
//   i_ram_o              RAM read data (combinational from o_mem_add)
//   o_mem_in/add/load    RAM write data, address, write enable
//   o_busy               a sequence owns the RAM
//   o_done               one-cycle completion pulse
//   o_fail, o_fail_add   sticky mismatch flag and first mismatch address
module ram16k_bist (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_mode,
  input  logic [15:0] i_fill,
  input  logic [15:0] i_cpu_in,
  input  logic [13:0] i_cpu_add,
  input  logic        i_cpu_load,
  input  logic [15:0] i_ram_o,
  output logic [15:0] o_mem_in,
  output logic [13:0] o_mem_add,
  output logic        o_mem_load,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fail,
  output logic [13:0] o_fail_add
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [13:0] LAST_ADD = 14'h3FFF;

  state_t      r_state;
  logic [13:0] r_cnt;
  logic        r_mode;
  logic [15:0] r_fill;
  logic        r_done;
  logic        r_fail;
  logic [13:0] r_fail_add;

  logic [15:0] w_pat;
  logic        w_mismatch;

  // Address-unique test pattern: the low address bits are repeated in the top
  // two bits so that no two addresses share a value.
  function automatic logic [15:0] pat(input logic [13:0] a);
    pat = {a[1:0], a} ^ 16'h5A5A;
  endfunction

  assign w_pat      = pat(r_cnt);
  assign w_mismatch = (i_ram_o != w_pat);

  // Sequencer FSM: state, address counter, latched request and result flags.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 14'd0;
      r_mode     <= 1'b0;
      r_fill     <= 16'h0000;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      r_fail_add <= 14'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_mode     <= i_mode;
            r_fill     <= i_fill;
            r_cnt      <= 14'd0;
            r_fail     <= 1'b0;
            r_fail_add <= 14'd0;
            r_state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (r_cnt == LAST_ADD) begin
            if (r_mode) begin
              // Only wrap point of the counter: restart for the read-back pass.
              r_cnt   <= 14'd0;
              r_state <= ST_CHECK;
            end else begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 14'd1;
          end
        end
        ST_CHECK: begin
          // Only the first mismatch is recorded; later ones leave fail_add alone.
          if (w_mismatch && !r_fail) begin
            r_fail     <= 1'b1;
            r_fail_add <= r_cnt;
          end
          if (r_cnt == LAST_ADD) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 14'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM port steering: CPU pass-through in IDLE, sequencer ownership otherwise.
  always_comb begin
    o_mem_in   = i_cpu_in;
    o_mem_add  = i_cpu_add;
    o_mem_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_mem_in   = i_cpu_in;
        o_mem_add  = i_cpu_add;
        o_mem_load = i_cpu_load & ~i_reset;
      end
      ST_FILL: begin
        o_mem_in   = r_mode ? w_pat : r_fill;
        o_mem_add  = r_cnt;
        o_mem_load = 1'b1;
      end
      ST_CHECK: begin
        o_mem_in   = 16'h0000;
        o_mem_add  = r_cnt;
        o_mem_load = 1'b0;
      end
      default: begin
        o_mem_in   = 16'h0000;
        o_mem_add  = 14'd0;
        o_mem_load = 1'b0;
      end
    endcase
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;
  assign o_fail     = r_fail;
  assign o_fail_add = r_fail_add;

endmodule

// File: tb/tb_ram16k_bist.sv
module tb_ram16k_bist;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [15:0] fill;
  logic [15:0] cpu_in;
  logic [13:0] cpu_add;
  logic        cpu_load;
  logic [15:0] ram_o;
  logic [15:0] mem_in;
  logic [13:0] mem_add;
  logic        mem_load;
  logic        busy;
  logic        done;
  logic        fail;
  logic [13:0] fail_add;

  logic [15:0] mem [0:16383];
  logic        inject;
  logic [15:0] fault;

  int checks   = 0;
  int failures = 0;

  ram16k_bist dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_mode     (mode),
    .i_fill     (fill),
    .i_cpu_in   (cpu_in),
    .i_cpu_add  (cpu_add),
    .i_cpu_load (cpu_load),
    .i_ram_o    (ram_o),
    .o_mem_in   (mem_in),
    .o_mem_add  (mem_add),
    .o_mem_load (mem_load),
    .o_busy     (busy),
    .o_done     (done),
    .o_fail     (fail),
    .o_fail_add (fail_add)
  );

  always #5 clk = ~clk;

  // RAM model with a bit-3 fault on two addresses during the read-back pass.
  assign fault = (inject && busy && !mem_load &&
                  (mem_add == 14'h1234 || mem_add == 14'h2000)) ? 16'h0008 : 16'h0000;
  assign ram_o = mem[mem_add] ^ fault;

  always @(posedge clk) begin
    if (mem_load) mem[mem_add] <= mem_in;
  end

  typedef struct {
    logic [15:0] cin;
    logic [13:0] cadd;
    logic        cload;
    logic [15:0] e_in;
    logic [13:0] e_add;
    logic        e_load;
  } pt_vec_t;

  typedef struct {
    logic [13:0] addr;
    logic [15:0] exp;
  } rd_vec_t;

  pt_vec_t pt [4];
  rd_vec_t rd_pt [4];
  rd_vec_t rd_clr [4];
  rd_vec_t rd_tst [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu_read(input logic [13:0] a, input logic [15:0] e, input string name);
    @(negedge clk);
    cpu_load = 1'b0;
    cpu_add  = a;
    #1;
    check(name, {16'h0000, ram_o}, {16'h0000, e});
  endtask

  // Runs one sequence; injects a CPU write and a second start while busy.
  task automatic run_seq(input logic m, input logic [15:0] f, input logic [15:0] first_val,
                         input int exp_len, input string name);
    int n;
    int early_done;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    fill  = f;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    fill  = 16'h0000;
    #1;
    check({name, "_first_add"},  {18'd0, mem_add},  32'h0);
    check({name, "_first_load"}, {31'd0, mem_load}, 32'h1);
    check({name, "_first_in"},   {16'd0, mem_in},   {16'd0, first_val});
    n = 0;
    early_done = 0;
    while (busy === 1'b1 && n < 40000) begin
      if (done) early_done++;
      if (n == 100) begin
        cpu_load = 1'b1;
        cpu_add  = 14'h0005;
        cpu_in   = 16'h1111;
      end else if (n == 101) begin
        cpu_load = 1'b0;
      end
      start = (n == 200);
      n++;
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    check({name, "_busy_len"},   n, exp_len);
    check({name, "_early_done"}, early_done, 0);
    check({name, "_done_pulse"}, {31'd0, done}, 32'h1);
    @(negedge clk);
    #1;
    check({name, "_done_drop"},  {31'd0, done}, 32'h0);
  endtask

  initial begin
    int n;
    int d;
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
    inject   = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    fill     = 16'h0000;
    cpu_in   = 16'h4321;
    cpu_add  = 14'h0123;
    cpu_load = 1'b1;

    pt[0] = '{16'h1234, 14'h0ABC, 1'b1, 16'h1234, 14'h0ABC, 1'b1};
    pt[1] = '{16'h0000, 14'h3FFF, 1'b0, 16'h0000, 14'h3FFF, 1'b0};
    pt[2] = '{16'hFFFF, 14'h0000, 1'b1, 16'hFFFF, 14'h0000, 1'b1};
    pt[3] = '{16'hA5A5, 14'h2AAA, 1'b1, 16'hA5A5, 14'h2AAA, 1'b1};
    rd_pt[0] = '{14'h0ABC, 16'h1234};
    rd_pt[1] = '{14'h0000, 16'hFFFF};
    rd_pt[2] = '{14'h2AAA, 16'hA5A5};
    rd_pt[3] = '{14'h3FFF, 16'h0000};
    rd_clr[0] = '{14'h0000, 16'hBEEF};
    rd_clr[1] = '{14'h1FFF, 16'hBEEF};
    rd_clr[2] = '{14'h3FFF, 16'hBEEF};
    rd_clr[3] = '{14'h0005, 16'hBEEF};
    rd_tst[0] = '{14'h0005, 16'h1A5F};
    rd_tst[1] = '{14'h3FFF, 16'hA5A5};
    rd_tst[2] = '{14'h1234, 16'h486E};
    rd_tst[3] = '{14'h2001, 16'h3A5B};

    // Reset state
    #2;
    check("rst_busy",     {31'd0, busy},     32'h0);
    check("rst_done",     {31'd0, done},     32'h0);
    check("rst_fail",     {31'd0, fail},     32'h0);
    check("rst_fail_add", {18'd0, fail_add}, 32'h0);
    check("rst_mem_load", {31'd0, mem_load}, 32'h0);
    check("rst_mem_add",  {18'd0, mem_add},  32'h0123);
    @(negedge clk);
    reset    = 1'b0;
    cpu_load = 1'b0;

    // Pass-through vectors
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_in   = pt[i].cin;
      cpu_add  = pt[i].cadd;
      cpu_load = pt[i].cload;
      #1;
      check($sformatf("pt%0d_in", i),   {16'd0, mem_in},   {16'd0, pt[i].e_in});
      check($sformatf("pt%0d_add", i),  {18'd0, mem_add},  {18'd0, pt[i].e_add});
      check($sformatf("pt%0d_load", i), {31'd0, mem_load}, {31'd0, pt[i].e_load});
    end
    for (int i = 0; i < 4; i++) cpu_read(rd_pt[i].addr, rd_pt[i].exp, $sformatf("pt_rd%0d", i));

    // Reset 100 cycles into a clear sequence
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    fill  = 16'h7777;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    cpu_load = 1'b1;
    cpu_add  = 14'h0003;
    cpu_in   = 16'hAAAA;
    reset    = 1'b1;
    #1;
    check("midrst_busy",     {31'd0, busy},     32'h0);
    check("midrst_mem_load", {31'd0, mem_load}, 32'h0);
    @(negedge clk);
    reset    = 1'b0;
    cpu_load = 1'b0;
    d = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      d += int'(done);
    end
    check("midrst_no_done", d, 0);

    // Clear sequence with arbitration stimulus, then read-back
    run_seq(1'b0, 16'hBEEF, 16'hBEEF, 16384, "clear");
    for (int i = 0; i < 4; i++) cpu_read(rd_clr[i].addr, rd_clr[i].exp, $sformatf("clr_rd%0d", i));

    // Fault-free self-test
    run_seq(1'b1, 16'h0000, 16'h5A5A, 32768, "selftest");
    check("st_fail",     {31'd0, fail},     32'h0);
    check("st_fail_add", {18'd0, fail_add}, 32'h0);
    for (int i = 0; i < 4; i++) cpu_read(rd_tst[i].addr, rd_tst[i].exp, $sformatf("st_rd%0d", i));

    // Fault injection with start held high through the done cycle
    inject = 1'b1;
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b1;
    @(negedge clk);
    #1;
    n = 0;
    while (busy === 1'b1 && n < 40000) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("flt_busy_len", n, 32768);
    check("flt_done",     {31'd0, done},     32'h1);
    check("flt_fail",     {31'd0, fail},     32'h1);
    check("flt_fail_add", {18'd0, fail_add}, 32'h1234);
    mode = 1'b0;
    fill = 16'h0F0F;
    @(negedge clk);
    #1;
    check("rearm_busy",     {31'd0, busy},     32'h1);
    check("rearm_done",     {31'd0, done},     32'h0);
    check("rearm_fail",     {31'd0, fail},     32'h0);
    check("rearm_fail_add", {18'd0, fail_add}, 32'h0);
    check("rearm_mem_in",   {16'd0, mem_in},   32'h0F0F);
    start  = 1'b0;
    inject = 1'b0;
    reset  = 1'b1;
    #1;
    check("rearm_abort_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
